// File: rtl/param_binary_divider_if.sv
// Request/result bundle between a datapath master and the sequential divider.
// Handshake: div_en is a request taken on a rising edge only while busy=0; done pulses for one cycle when results are valid.
interface param_binary_divider_if #(
  parameter int DATA_W = 16,
  parameter int QUOT_W = 8
);
  logic              div_en;
  logic              signed_mode;
  logic [DATA_W-1:0] g_dividend_Q;
  logic [DATA_W-1:0] g_divider_Q;
  logic [QUOT_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              done;
  logic              busy;
  logic              div_by_zero;
  logic              overflow;

  modport master (
    output div_en, signed_mode, g_dividend_Q, g_divider_Q,
    input  quotient, remainder, done, busy, div_by_zero, overflow
  );

  modport slave (
    input  div_en, signed_mode, g_dividend_Q, g_divider_Q,
    output quotient, remainder, done, busy, div_by_zero, overflow
  );
endinterface

// File: rtl/param_binary_divider.sv
// Sequential restoring divider, one quotient bit per clock, with signed mode,
// saturating quotient and divide-by-zero reporting. Requires DATA_W >= 2.
module param_binary_divider #(
  parameter int DATA_W = 16,
  parameter int QUOT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  param_binary_divider_if.slave   bus,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W:0] U_MAX     = {{(DATA_W + 1 - QUOT_W){1'b0}}, {QUOT_W{1'b1}}};
  localparam logic [DATA_W:0] S_MAX     = U_MAX >> 1;
  localparam logic [DATA_W:0] S_MIN_MAG = S_MAX + {{DATA_W{1'b0}}, 1'b1};
  localparam logic [QUOT_W-1:0] Q_ONES  = '1;
  localparam logic [QUOT_W-1:0] Q_SMAX  = Q_ONES >> 1;
  localparam logic [QUOT_W-1:0] Q_SMIN  = ~Q_SMAX;

  state_t            state;
  logic [DATA_W-1:0] dq;        // dividend bits shift out the top, quotient bits shift in
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] div_mag;
  logic [CNT_W-1:0]  cnt;
  logic              sign_q, sign_r, sm_q, dz_q;

  logic [DATA_W:0]   trial;
  logic              fits;
  logic [DATA_W-1:0] sub;
  logic              dvd_neg, dvr_neg;
  logic [DATA_W-1:0] dvd_mag, dvr_mag;
  logic [DATA_W-1:0] rem_out;
  logic [QUOT_W-1:0] q_neg;
  logic [QUOT_W-1:0] q_sat;
  logic              ovf_sat;

  assign dbg_state = state;

  always_comb begin
    trial   = {partial, dq[DATA_W-1]};
    fits    = trial >= {1'b0, div_mag};
    sub     = trial[DATA_W-1:0] - div_mag;
    dvd_neg = bus.signed_mode & bus.g_dividend_Q[DATA_W-1];
    dvr_neg = bus.signed_mode & bus.g_divider_Q[DATA_W-1];
    dvd_mag = dvd_neg ? -bus.g_dividend_Q : bus.g_dividend_Q;
    dvr_mag = dvr_neg ? -bus.g_divider_Q : bus.g_divider_Q;
    rem_out = sign_r ? -partial : partial;
    q_neg   = -dq[QUOT_W-1:0];
  end

  // Quotient magnitude is compared one bit wider so QUOT_W == DATA_W still saturates correctly.
  always_comb begin
    q_sat   = dq[QUOT_W-1:0];
    ovf_sat = 1'b0;
    if (!sm_q) begin
      if ({1'b0, dq} > U_MAX) begin
        q_sat   = Q_ONES;
        ovf_sat = 1'b1;
      end
    end else if (sign_q) begin
      if ({1'b0, dq} > S_MIN_MAG) begin
        q_sat   = Q_SMIN;
        ovf_sat = 1'b1;
      end else begin
        q_sat   = q_neg;
      end
    end else if ({1'b0, dq} > S_MAX) begin
      q_sat   = Q_SMAX;
      ovf_sat = 1'b1;
    end
    if (dz_q) begin
      ovf_sat = 1'b0;
      q_sat   = !sm_q ? Q_ONES : (sign_r ? Q_SMIN : Q_SMAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      dq              <= '0;
      partial         <= '0;
      div_mag         <= '0;
      cnt             <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      sm_q            <= 1'b0;
      dz_q            <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.div_en) begin
            sm_q     <= bus.signed_mode;
            sign_q   <= dvd_neg ^ dvr_neg;
            sign_r   <= dvd_neg;
            div_mag  <= dvr_mag;
            bus.busy <= 1'b1;
            if (bus.g_divider_Q == '0) begin
              // Parking the dividend in partial lets FIN re-sign it as the remainder.
              dz_q    <= 1'b1;
              partial <= dvd_mag;
              dq      <= '0;
              state   <= FIN;
            end else begin
              dz_q    <= 1'b0;
              partial <= '0;
              dq      <= dvd_mag;
              cnt     <= CNT_W'(DATA_W);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          partial <= fits ? sub : trial[DATA_W-1:0];
          dq      <= {dq[DATA_W-2:0], fits};
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIN;
        end
        FIN: begin
          bus.quotient    <= q_sat;
          bus.remainder   <= rem_out;
          bus.div_by_zero <= dz_q;
          bus.overflow    <= ovf_sat;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
